// File: rtl/vga_timing_pkg.sv
// 640x480 raster constants and monitor state encoding for the VGA timing monitor.
`timescale 1ns/1ps
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = 525;
  localparam int VGA_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } mon_state_t;
endpackage

// File: rtl/vga_timing_monitor_sync_meter.sv
// One sync axis: edge strobes, saturating period counter and low-width counter.
`timescale 1ns/1ps
module vga_sync_meter #(
  parameter int CW    = 10,
  parameter int LW    = 7,
  parameter int TOTAL = 800,
  parameter int WIDTH = 96
) (
  input  logic          clk25,
  input  logic          reset_n,
  input  logic          sync,
  input  logic          count_en,
  output logic [CW-1:0] cnt,
  output logic          fall,
  output logic          rise,
  output logic          period_ok,
  output logic          width_ok
);
  logic          sync_q;
  logic [LW-1:0] low;

  assign fall      = sync_q & ~sync;
  assign rise      = ~sync_q & sync;
  assign period_ok = (cnt == CW'(TOTAL - 1));
  assign width_ok  = (low == LW'(WIDTH));

  // low restarts at the falling edge so it includes that first low sample
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b1;
      cnt    <= '0;
      low    <= '0;
    end else begin
      sync_q <= sync;
      if (fall)
        cnt <= '0;
      else if (count_en && cnt != '1)
        cnt <= cnt + 1'b1;
      if (fall)
        low <= LW'(count_en);
      else if (!sync && count_en && low != '1)
        low <= low + 1'b1;
    end
  end
endmodule

// File: rtl/vga_timing_monitor.sv
// Passive VGA stream checker: timing lock, coordinate recovery, probe capture.
// Probe capture is built only when VGA_MON_PROBE_EN is defined.
`timescale 1ns/1ps
module vga_timing_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic        clk25,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_active,
  output logic        locked,
  output logic        err_hline,
  output logic        err_vframe,
  output logic        err_sticky,
  output logic [15:0] frame_count,
  output logic [2:0]  probe_rgb,
  output logic        probe_valid
);
  localparam logic [9:0] H_LO = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_HI = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_LO = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_HI = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

  logic [9:0] h_cnt, v_cnt, cur_x, cur_y;
  logic       hs_fall, hs_rise, h_period_ok, h_width_ok;
  logic       vs_fall, vs_rise, v_period_ok, v_width_ok;
  logic       err_h, err_v, err_any, act;
  logic [7:0] good;
  mon_state_t state;

  vga_sync_meter #(
    .CW(10), .LW(7), .TOTAL(H_TOTAL), .WIDTH(H_SYNC)
  ) u_hmeter (
    .clk25(clk25), .reset_n(reset_n),
    .sync(hsync), .count_en(1'b1),
    .cnt(h_cnt), .fall(hs_fall), .rise(hs_rise),
    .period_ok(h_period_ok), .width_ok(h_width_ok)
  );

  vga_sync_meter #(
    .CW(10), .LW(7), .TOTAL(V_TOTAL), .WIDTH(V_SYNC)
  ) u_vmeter (
    .clk25(clk25), .reset_n(reset_n),
    .sync(vsync), .count_en(hs_fall),
    .cnt(v_cnt), .fall(vs_fall), .rise(vs_rise),
    .period_ok(v_period_ok), .width_ok(v_width_ok)
  );

  assign err_h   = (hs_fall & ~h_period_ok) | (hs_rise & ~h_width_ok);
  assign err_v   = (vs_fall & ~v_period_ok) | (vs_rise & ~v_width_ok);
  assign err_any = err_h | err_v;
  assign act     = (h_cnt >= H_LO) && (h_cnt <= H_HI) &&
                   (v_cnt >= V_LO) && (v_cnt <= V_HI);
  assign cur_x   = h_cnt - H_LO;
  assign cur_y   = v_cnt - V_LO;
  assign locked  = (state == LOCKED);

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      rx_active <= 1'b0;
      rx_x      <= '0;
      rx_y      <= '0;
    end else begin
      rx_active <= act;
      rx_x      <= act ? cur_x : '0;
      rx_y      <= act ? cur_y : '0;
    end
  end

  // errors in SEARCH are reported but cannot hold off the first frame edge
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SEARCH;
      good        <= '0;
      err_hline   <= 1'b0;
      err_vframe  <= 1'b0;
      err_sticky  <= 1'b0;
      frame_count <= '0;
    end else begin
      err_hline  <= err_h;
      err_vframe <= err_v;
      unique case (state)
        SEARCH: begin
          if (vs_fall) begin
            state <= TRACK;
            good  <= '0;
          end
        end
        TRACK: begin
          if (err_any) begin
            state <= SEARCH;
          end else if (vs_fall) begin
            good <= good + 8'd1;
            if (good + 8'd1 >= LOCK_N)
              state <= LOCKED;
          end
        end
        LOCKED: begin
          if (err_any) begin
            state      <= SEARCH;
            err_sticky <= 1'b1;
          end else if (vs_fall) begin
            frame_count <= frame_count + 16'd1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

`ifdef VGA_MON_PROBE_EN
  logic [9:0] px_q, py_q;

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      px_q        <= '0;
      py_q        <= '0;
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
    end else begin
      probe_valid <= 1'b0;
      if (vs_fall) begin
        px_q <= probe_x;
        py_q <= probe_y;
      end
      if (locked && act && cur_x == px_q && cur_y == py_q) begin
        probe_rgb   <= rgb;
        probe_valid <= 1'b1;
      end
    end
  end
`else
  logic probe_unused;
  assign probe_unused = ^{probe_x, probe_y, rgb};
  assign probe_rgb    = 3'b000;
  assign probe_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a reduced 30x16 raster.
`timescale 1ns/1ps
module tb_vga_timing_monitor;
  localparam int HT = 30, HSW = 4, HBP = 4, HA = 16;
  localparam int VT = 16, VSW = 2, VBP = 3, VA = 8;

`ifdef VGA_MON_PROBE_EN
  localparam int         PV   = 1;
  localparam logic [2:0] PRGB4 = 3'b101;
  localparam logic [2:0] PRGB5 = 3'b010;
`else
  localparam int         PV   = 0;
  localparam logic [2:0] PRGB4 = 3'b000;
  localparam logic [2:0] PRGB5 = 3'b000;
`endif

  logic        clk25 = 1'b0;
  logic        reset_n, hsync, vsync;
  logic [2:0]  rgb;
  logic [9:0]  probe_x, probe_y;
  logic [9:0]  rx_x, rx_y;
  logic        rx_active, locked, err_hline, err_vframe, err_sticky;
  logic [15:0] frame_count;
  logic [2:0]  probe_rgb;
  logic        probe_valid;

  always #20 clk25 = ~clk25;

  vga_timing_monitor #(
    .H_ACTIVE(HA), .H_SYNC(HSW), .H_BP(HBP), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VSW), .V_BP(VBP), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .clk25(clk25), .reset_n(reset_n),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .probe_x(probe_x), .probe_y(probe_y),
    .rx_x(rx_x), .rx_y(rx_y), .rx_active(rx_active),
    .locked(locked), .err_hline(err_hline), .err_vframe(err_vframe),
    .err_sticky(err_sticky), .frame_count(frame_count),
    .probe_rgb(probe_rgb), .probe_valid(probe_valid)
  );

  typedef struct {
    int         line;
    int         pos;
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
  } vec_t;

  vec_t tbl[9];
  int n_cmp = 0, n_bad = 0;

  int f_eh, f_ev, f_pv;
  logic st_locked, w_eh, w_lk, do_table;
  logic [15:0] st_fc;
  int short_line, narrow_line, chg_line, stop_line, w_line, w_pos;
  int probe_line, probe_pos;
  logic [9:0] next_px, next_py;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {19'd0, rx_x, rx_y, rx_active, locked, err_hline, err_vframe,
            err_sticky, frame_count, probe_rgb, probe_valid};
  endfunction

  // drive inputs away from the sampling edge; outputs then reflect them
  task automatic step(input logic h, input logic v, input logic [2:0] c);
    @(negedge clk25);
    hsync = h;
    vsync = v;
    rgb   = c;
    @(posedge clk25);
    #1;
  endtask

  task automatic frame();
    int len, hw;
    logic [2:0] c;
    f_eh = 0; f_ev = 0; f_pv = 0;
    w_eh = 1'b0; w_lk = 1'b1;
    for (int l = 0; l <= stop_line; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      hw  = (l == narrow_line) ? HSW - 1 : HSW;
      if (l == chg_line) begin
        probe_x = next_px;
        probe_y = next_py;
      end
      for (int p = 0; p < len; p++) begin
        c = (l == probe_line && p == probe_pos) ? 3'b101 : 3'b010;
        step(!(p < hw), !(l < VSW), c);
        f_eh += int'(err_hline);
        f_ev += int'(err_vframe);
        f_pv += int'(probe_valid);
        if (l == 0 && p == 0) begin
          st_locked = locked;
          st_fc     = frame_count;
        end
        if (l == w_line && p == w_pos) begin
          w_eh = err_hline;
          w_lk = locked;
        end
        if (do_table)
          foreach (tbl[i])
            if (tbl[i].line == l && tbl[i].pos == p) begin
              chk($sformatf("rx_active[%0d]", i), rx_active, tbl[i].act);
              chk($sformatf("rx_x[%0d]", i), rx_x, tbl[i].x);
              chk($sformatf("rx_y[%0d]", i), rx_y, tbl[i].y);
            end
      end
    end
  endtask

  initial begin
    // generator cycle (line,pos) is seen by the DUT as h_cnt=pos-1, v_cnt=line
    tbl[0] = '{5,  9,  1'b1, 10'd0,  10'd0};
    tbl[1] = '{12, 24, 1'b1, 10'd15, 10'd7};
    tbl[2] = '{5,  8,  1'b0, 10'd0,  10'd0};
    tbl[3] = '{12, 25, 1'b0, 10'd0,  10'd0};
    tbl[4] = '{4,  9,  1'b0, 10'd0,  10'd0};
    tbl[5] = '{13, 9,  1'b0, 10'd0,  10'd0};
    tbl[6] = '{8,  17, 1'b1, 10'd8,  10'd3};
    tbl[7] = '{5,  0,  1'b0, 10'd0,  10'd0};
    tbl[8] = '{10, 12, 1'b1, 10'd3,  10'd5};

    short_line = -1; narrow_line = -1; chg_line = -1;
    w_line = -1; w_pos = -1; stop_line = VT - 1;
    probe_line = 9; probe_pos = 17;
    do_table = 1'b0;
    next_px = 10'd2; next_py = 10'd1;
    reset_n = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = 3'b000;
    probe_x = 10'd8; probe_y = 10'd4;

    repeat (3) @(posedge clk25);
    #1;
    chk("reset_outputs", all_out(), 64'd0);
    @(negedge clk25);
    reset_n = 1'b1;
    repeat (3) step(1'b1, 1'b1, 3'b000);

    frame();
    chk("f1_start_locked", st_locked, 1'b0);
    frame();
    chk("f2_start_locked", st_locked, 1'b0);
    chk("f2_err_hline", f_eh, 0);
    chk("f2_err_vframe", f_ev, 0);
    chk("f2_end_locked", locked, 1'b0);
    frame();
    chk("f3_start_locked", st_locked, 1'b1);
    chk("f3_start_fcount", st_fc, 16'd0);

    chg_line = 3; do_table = 1'b1;
    frame();
    chk("f4_start_fcount", st_fc, 16'd1);
    chk("f4_err_hline", f_eh, 0);
    chk("f4_err_vframe", f_ev, 0);
    chk("f4_probe_pulses", f_pv, PV);
    chk("f4_probe_rgb", probe_rgb, PRGB4);
    chk("f4_sticky", err_sticky, 1'b0);
    chg_line = -1; do_table = 1'b0;

    short_line = 10; w_line = 11; w_pos = 0;
    frame();
    chk("f5_start_fcount", st_fc, 16'd2);
    chk("short_err_pulse", w_eh, 1'b1);
    chk("short_locked_drop", w_lk, 1'b0);
    chk("short_err_count", f_eh, 1);
    chk("short_err_vframe", f_ev, 0);
    chk("short_sticky", err_sticky, 1'b1);
    chk("f5_probe_pulses", f_pv, PV);
    chk("f5_probe_rgb", probe_rgb, PRGB5);
    short_line = -1; w_line = -1;

    frame();
    chk("f6_start_locked", st_locked, 1'b0);
    frame();
    chk("f7_start_locked", st_locked, 1'b0);
    frame();
    chk("f8_relocked", st_locked, 1'b1);
    chk("f8_start_fcount", st_fc, 16'd2);

    narrow_line = 7; w_line = 7; w_pos = 3;
    frame();
    chk("f9_start_fcount", st_fc, 16'd3);
    chk("narrow_err_pulse", w_eh, 1'b1);
    chk("narrow_locked_drop", w_lk, 1'b0);
    chk("narrow_err_count", f_eh, 1);
    chk("f9_end_locked", locked, 1'b0);
    narrow_line = -1; w_line = -1;

    stop_line = 8;
    frame();
    chk("pre_reset_sticky", err_sticky, 1'b1);
    @(negedge clk25);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_out(), 64'd0);
    @(posedge clk25);
    #1;
    chk("reset_edge_outputs", all_out(), 64'd0);
    @(negedge clk25);
    reset_n = 1'b1;
    repeat (3) step(1'b1, 1'b1, 3'b000);
    stop_line = VT - 1;

    frame();
    chk("f11_start_locked", st_locked, 1'b0);
    frame();
    chk("f12_start_locked", st_locked, 1'b0);
    frame();
    chk("f13_relocked", st_locked, 1'b1);
    chk("f13_fcount", st_fc, 16'd0);
    chk("f13_sticky", err_sticky, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_monitor.md
# vga_timing_monitor

- Passive receiver for the 640x480 VGA stream the display pipeline drives.
- Samples hsync, vsync and the 3-bit final RGB in the clk25 domain and checks line and frame timing against the nominal 800x525 raster.
- Recovers the pixel coordinate, reports lock and timing errors, and captures the colour of one probe pixel per frame.
- Sits beside the VGA output in the top level as an on-chip self-check. Benches reuse it as the stream checker.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_SYNC, 96, hsync low width (cycles)
- H_BP, 48, horizontal back porch
- H_TOTAL, 800, cycles per line
- V_ACTIVE, 480, visible lines
- V_SYNC, 2, vsync low width (lines)
- V_BP, 33, vertical back porch
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
- clk25  in  1  pixel clock; all logic on its rising edge. One clock; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous active-low reset
- hsync  in  1  horizontal sync, active-low, same clock domain (no synchronizer)
- vsync  in  1  vertical sync, active-low
- rgb  in  3  {R,G,B} pixel bits
- probe_x  in  10  probe column
- probe_y  in  10  probe row
- rx_x  out  10  recovered column, valid when rx_active
- rx_y  out  10  recovered row, valid when rx_active
- rx_active  out  1  current sample is inside the visible window
- locked  out  1  timing locked
- err_hline  out  1  one-cycle pulse on a bad line period or hsync width
- err_vframe  out  1  one-cycle pulse on a bad frame period or vsync width
- err_sticky  out  1  set by any error while locked; cleared only by reset
- frame_count  out  16  good frames since reset, wraps at 65535->0
- probe_rgb  out  3  last captured probe colour
- probe_valid  out  1  one-cycle pulse when probe_rgb updates

## Operation
- **Edge detection:**
  - hs_q and vs_q hold the previous samples.
  - Falling edge = q==1 and input==0. Rising edge = q==0 and input==1.
- **h_cnt (10 bit):**
  - Cleared to 0 in the hsync-falling-edge cycle.
  - Otherwise increments, saturating at 1023.
  - The line check at each falling edge requires h_cnt==H_TOTAL-1.
- **hs_low (7 bit):**
  - Counts low cycles, saturating.
  - At a rising edge it must equal H_SYNC.
  - A failure of either horizontal check pulses err_hline.
- **v_cnt (10 bit):**
  - Increments on each hsync falling edge.
  - A vsync falling edge clears it to 0. If both edges occur in the same cycle, the clear wins.
  - The frame check at the vsync falling edge requires v_cnt==V_TOTAL-1.
- **vs_low:**
  - Counts hsync falling edges while vsync is low.
  - Must equal V_SYNC at the vsync rising edge.
  - A failure of either vertical check pulses err_vframe.
- **Visible window:**
  - rx_active = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - rx_x = h_cnt-(H_SYNC+H_BP), rx_y = v_cnt-(V_SYNC+V_BP).
  - When not active, rx_x=0 and rx_y=0.
- **FSM states:** SEARCH, TRACK, LOCKED.
  - SEARCH -> TRACK on the first vsync falling edge; good-frame counter = 0.
  - TRACK: each error-free vsync falling edge increments the good-frame counter. Reaching LOCK_FRAMES -> LOCKED.
  - TRACK: any error -> SEARCH.
  - LOCKED: any error -> SEARCH and sets err_sticky.
  - locked = (state==LOCKED).
- **frame_count:** increments on each error-free vsync falling edge while in LOCKED.
- **Probe capture:**
  - probe_x and probe_y are latched at each vsync falling edge; changes mid-frame have no effect until the next frame.
  - When locked and rx_active and the coordinate equals the latched probe: probe_rgb<=rgb and probe_valid pulses.
  - An out-of-range probe never fires.

## Timing
- All outputs are registered, with latency 1: the output in cycle n+1 reflects the inputs sampled in cycle n.
- Reset value of every output is 0, including probe_rgb and frame_count. The FSM resets to SEARCH and all counters to 0.
- Reset asserted mid-frame clears everything asynchronously. Relock needs 1+LOCK_FRAMES vsync falling edges after release.
- locked rises 1 cycle after the qualifying vsync falling edge and falls 1 cycle after the cycle in which the error is detected.
- An error and a good-frame qualification in the same cycle: the error wins.

## Configuration
- Macro VGA_MON_PROBE_EN.
- Defined: the probe latch and capture logic is present.
- Undefined: the probe logic is removed; probe_rgb ties to 3'b000 and probe_valid to 0. probe_x and probe_y are ignored.

## Structure
- Package vga_timing_pkg holds:
  - the 640x480 timing constants (the defaults above);
  - the monitor state enum {SEARCH, TRACK, LOCKED}.
- Sub-module vga_sync_meter is instantiated twice: horizontal with count_en=1, vertical with count_en=hsync falling edge.
- Each instance performs edge detection, period counting and low-width counting, and outputs period_ok, width_ok and edge strobes.

## Test plan
- **Lock:** nominal timing for 3 frames -> locked=1 one cycle after the 3rd vsync falling edge; frame_count=0 there and 1 after frame 4.
- **Coordinate recovery:** on line v_cnt=35, sample at h_cnt=144 -> next cycle rx_active=1, rx_x=0, rx_y=0. h_cnt=783 on line 514 -> rx_x=639, rx_y=479.
- **Short line:** one 799-cycle line while locked -> err_hline pulses once; locked=0; err_sticky=1; relock after 3 further vsync edges.
- **hsync width:** hsync low for 95 cycles -> err_hline at the rising edge; the FSM leaves TRACK/LOCKED.
- **Probe:** probe=(320,240), rgb=3'b101 at that pixel -> one probe_valid per frame, probe_rgb=101. Probe changed mid-frame -> old probe is used until the next vsync.
- **Reset and sync edges:** reset_n low mid-frame -> all outputs 0 next edge; coincident hsync/vsync falling edges -> v_cnt=0, no error.
